heap_sequencer: RTL and testbench
=================================

# heap_sequencer

Upstream command sequencer for the 16-entry 8-bit max-heap. It accepts keys on a valid/ready stream and converts them into single-cycle `push` strobes, spacing them so the heap finishes heapify before the next command. On request it issues `pop` strobes and returns keys in descending order on an output valid/ready stream. It keeps its own occupancy count, because the heap exposes no busy indication.

## Interface
- `DEPTH`, 16: heap capacity in entries; must match the heap array size.
- `SETTLE_CYCLES`, 6: idle cycles after each push/pop strobe; minimum 1; 6 covers 4 swap levels plus margin.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  key offered.
- `in_data`  in  8  key value.
- `in_ready`  out  1  combinational: `state==IDLE && !drain && count<DEPTH`.
- `drain`  in  1  level; while high, the block pops until empty.
- `out_valid`  out  1  sorted key available.
- `out_data`  out  8  sorted key.
- `out_ready`  in  1  consumer accepts.
- `heap_push`  out  1  one-cycle push strobe to the heap.
- `heap_pop`  out  1  one-cycle pop strobe to the heap.
- `heap_data_in`  out  8  key driven to the heap; valid with `heap_push`.
- `heap_data_out`  in  8  heap root output, registered by the heap on the pop edge.
- `count`  out  5  entries currently held, 0..DEPTH.
- `drain_done`  out  1  one-cycle pulse when a drain empties the heap.
- `err`  out  1  sticky consistency error (see Configuration).

## Operation
- States: IDLE, PUSH, POP, SETTLE, HOLD. SETTLE remembers the originating op in a 1-bit register `op_is_pop`.
- Reset: state IDLE; `count`=0; `out_valid`, `heap_push`, `heap_pop`, `drain_done`, `err` = 0; `out_data` and `heap_data_in` = 0.
- IDLE:
  - If `drain && count!=0`, go to POP. Drain has priority over input; `in_ready` is already low.
  - Else, on `in_valid && in_ready`, register `in_data` into `heap_data_in` and go to PUSH.
- PUSH: `heap_push`=1 for exactly this cycle; `count` increments; load the settle counter with SETTLE_CYCLES; go to SETTLE.
- POP: `heap_pop`=1 for exactly this cycle; `count` decrements; load the settle counter; go to SETTLE.
- SETTLE: decrement the counter. On the last cycle:
  - After a push, return to IDLE.
  - After a pop, register `out_data<=heap_data_out`, set `out_valid`=1, and go to HOLD.
- HOLD: keep `out_valid`/`out_data` stable until `out_ready`. On acceptance, clear `out_valid` and go to IDLE. If `count` is now 0 and `drain` was high at acceptance, pulse `drain_done`.
- `drain` is sampled only in IDLE. Dropping it mid-pop completes the current pop and delivery, then stops.
- Full: at `count==DEPTH`, `in_ready`=0 and no push is ever issued.
- Empty: with `count==0`, `drain` high yields no pop and no `drain_done`.
- `count` is 5-bit unsigned, never wraps; increments and decrements are guarded by the conditions above.
- An asynchronous reset mid-operation returns to the reset state immediately. An in-flight strobe is lost, and the heap must be reset together with this block.

## Timing
- Push: handshake in cycle N (IDLE); `heap_push` high in N+1; SETTLE N+2..N+1+S; `in_ready` can be high again in N+2+S. Sustained accept rate is one key per S+2 cycles (S = SETTLE_CYCLES).
- Pop: decision in cycle M; `heap_pop` high in M+1; `out_valid` high from M+2+S. With `out_ready` held high, the next `heap_pop` occurs at M+4+S, giving one key per S+3 cycles.
- `heap_push` and `heap_pop` are never high together, and never in consecutive cycles.
- `in_ready` has a combinational path from `drain`; all other outputs are registered.

## Configuration
- `HEAP_SEQ_CHECK_EN` defined:
  - Adds `heap_full` and `heap_empty` inputs (1 bit each) from the heap.
  - In IDLE, `err` sets and stays set until reset if `heap_empty != (count==0)` or `heap_full != (count==DEPTH)`.
  - `err` also sets if a push is attempted while `heap_full` is high. The push is then suppressed and `count` is unchanged.
- Undefined: those ports do not exist, and `err` is tied 0.

## Test plan
- Reset, then push 5, 200, 17 with S=6 -> `heap_push` strobes exactly 8 cycles apart; `count`=3; `in_ready` low during each push/settle window.
- Push 5, 200, 17, 42; hold `drain` high and `out_ready` high -> output sequence 200, 42, 17, 5; `drain_done` pulses once after the 5 is accepted; `count`=0.
- Push 16 keys 0..15 -> `count`=16 and `in_ready` held low; a 17th `in_valid` is never accepted and produces no `heap_push`.
- Drain with `out_ready` low for 10 cycles -> `out_valid` and `out_data` stable across all 10 cycles; no second `heap_pop` before acceptance.
- Raise `drain` while a push is in SETTLE -> the push completes, the next IDLE selects POP, and `in_valid` is ignored until drain completes.
- Assert `rst_n` low during SETTLE of a pop -> all outputs return to reset values immediately; `count`=0 after release. With `HEAP_SEQ_CHECK_EN`, force `heap_empty`=0 while `count`=0 -> `err` sets and stays set.

Source files
------------

// File: rtl/heap_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | heap_sequencer_if : key stream in/out and heap command bus (rev 1.0)        |
// +----------------------------------------------------------------------------+
interface heap_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       heap_push;
  logic       heap_pop;
  logic [7:0] heap_data_in;
  logic [7:0] heap_data_out;
`ifdef HEAP_SEQ_CHECK_EN
  logic       heap_full;
  logic       heap_empty;
`endif

  modport master (
    input  in_valid, in_data, out_ready, heap_data_out,
`ifdef HEAP_SEQ_CHECK_EN
    input  heap_full, heap_empty,
`endif
    output in_ready, out_valid, out_data, heap_push, heap_pop, heap_data_in
  );

  modport slave (
    output in_valid, in_data, out_ready, heap_data_out,
`ifdef HEAP_SEQ_CHECK_EN
    output heap_full, heap_empty,
`endif
    input  in_ready, out_valid, out_data, heap_push, heap_pop, heap_data_in
  );
endinterface
`default_nettype wire

// File: rtl/heap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | heap_sequencer : paces push/pop strobes to a max-heap, streams sorted keys  |
// | optional HEAP_SEQ_CHECK_EN adds heap_full/heap_empty consistency checking  |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module heap_sequencer #(
  parameter int DEPTH         = 16,
  parameter int SETTLE_CYCLES = 6
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  heap_sequencer_if.master bus,
  input  wire logic        drain_i,
  output logic [4:0]       count_o,
  output logic             drain_done_o,
  output logic             err_o
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUSH   = 3'd1,
    S_POP    = 3'd2,
    S_SETTLE = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            op_is_pop_q, op_is_pop_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [4:0]      count_q, count_d;
  logic            heap_push_q, heap_push_d;
  logic            heap_pop_q, heap_pop_d;
  logic [7:0]      heap_data_in_q, heap_data_in_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            drain_done_q, drain_done_d;
  logic            w_in_ready;
  logic            w_push_blocked;

  assign w_in_ready = (state_q == S_IDLE) && !drain_i && (count_q < 5'(DEPTH));

`ifdef HEAP_SEQ_CHECK_EN
  logic err_q;
  logic w_err_set;

  // A push offered while the heap claims full is dropped rather than issued.
  assign w_push_blocked = bus.heap_full;
  assign w_err_set = (state_q == S_IDLE) &&
                     ((bus.heap_empty != (count_q == 5'd0)) ||
                      (bus.heap_full  != (count_q == 5'(DEPTH))) ||
                      (bus.in_valid && w_in_ready && bus.heap_full));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (w_err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign w_push_blocked = 1'b0;
  assign err_o          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_is_pop_q    <= 1'b0;
      settle_q       <= '0;
      count_q        <= 5'd0;
      heap_push_q    <= 1'b0;
      heap_pop_q     <= 1'b0;
      heap_data_in_q <= 8'd0;
      out_valid_q    <= 1'b0;
      out_data_q     <= 8'd0;
      drain_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_is_pop_q    <= op_is_pop_d;
      settle_q       <= settle_d;
      count_q        <= count_d;
      heap_push_q    <= heap_push_d;
      heap_pop_q     <= heap_pop_d;
      heap_data_in_q <= heap_data_in_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      drain_done_q   <= drain_done_d;
    end
  end

  // Strobes are registered, so they are raised on the edge entering PUSH/POP.
  always_comb begin
    state_d        = state_q;
    op_is_pop_d    = op_is_pop_q;
    settle_d       = settle_q;
    count_d        = count_q;
    heap_push_d    = 1'b0;
    heap_pop_d     = 1'b0;
    heap_data_in_d = heap_data_in_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    drain_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (drain_i && (count_q != 5'd0)) begin
          state_d    = S_POP;
          heap_pop_d = 1'b1;
        end else if (bus.in_valid && w_in_ready && !w_push_blocked) begin
          heap_data_in_d = bus.in_data;
          heap_push_d    = 1'b1;
          state_d        = S_PUSH;
        end
      end
      S_PUSH: begin
        count_d     = count_q + 5'd1;
        settle_d    = SW'(SETTLE_CYCLES);
        op_is_pop_d = 1'b0;
        state_d     = S_SETTLE;
      end
      S_POP: begin
        count_d     = count_q - 5'd1;
        settle_d    = SW'(SETTLE_CYCLES);
        op_is_pop_d = 1'b1;
        state_d     = S_SETTLE;
      end
      S_SETTLE: begin
        settle_d = settle_q - SW'(1);
        if (settle_q == SW'(1)) begin
          if (op_is_pop_q) begin
            out_data_d  = bus.heap_data_out;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d  = 1'b0;
          state_d      = S_IDLE;
          drain_done_d = (count_q == 5'd0) && drain_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.heap_push    = heap_push_q;
  assign bus.heap_pop     = heap_pop_q;
  assign bus.heap_data_in = heap_data_in_q;
  assign count_o          = count_q;
  assign drain_done_o     = drain_done_q;
endmodule
`default_nettype wire

// File: tb/tb_heap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_heap_sequencer : directed bench with behavioural heap and out scoreboard |
// +----------------------------------------------------------------------------+
module tb_heap_sequencer;
  localparam int S = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drain = 1'b0;
  logic [4:0] count;
  logic       drain_done;
  logic       err;

  heap_sequencer_if bus ();

  heap_sequencer #(.DEPTH(16), .SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .drain_i      (drain),
    .count_o      (count),
    .drain_done_o (drain_done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural heap: root is registered on the pop edge.
  logic [7:0] mem[$];
  int         msize = 0;
  int         mi;
  logic       force_not_empty = 1'b0;
`ifdef HEAP_SEQ_CHECK_EN
  assign bus.heap_empty = force_not_empty ? 1'b0 : (msize == 0);
  assign bus.heap_full  = (msize == 16);
`endif

  initial begin
    bus.heap_data_out = 8'd0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mem.delete();
        msize <= 0;
        bus.heap_data_out <= 8'd0;
      end else begin
        if (bus.heap_push) mem.push_back(bus.heap_data_in);
        if (bus.heap_pop && mem.size() > 0) begin
          mi = 0;
          for (int i = 1; i < mem.size(); i++) if (mem[i] > mem[mi]) mi = i;
          bus.heap_data_out <= mem[mi];
          mem.delete(mi);
        end
        msize <= mem.size();
      end
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  logic [7:0] exp_q[$];
  int push_t[$];
  int pop_t[$];
  int cyc = 0, n_push = 0, n_pop = 0, n_dd = 0, n_viol = 0, since_push = 99;
  logic prev_strobe = 1'b0;
  logic [7:0] e;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        since_push  = 99;
        prev_strobe = 1'b0;
        continue;
      end
      if (bus.heap_push) begin n_push++; push_t.push_back(cyc); end
      if (bus.heap_pop) begin n_pop++; pop_t.push_back(cyc); end
      if (bus.heap_push && bus.heap_pop) n_viol++;
      if ((bus.heap_push || bus.heap_pop) && prev_strobe) n_viol++;
      prev_strobe = bus.heap_push || bus.heap_pop;
      if (bus.heap_push) since_push = 0;
      else if (since_push < 99) since_push++;
      if (bus.in_ready && since_push >= 1 && since_push <= S) n_viol++;
      if (drain_done) n_dd++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_output", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sb_out_data", bus.out_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_key(input logic [7:0] k);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = k;
    while (!bus.in_ready && n < 200) begin step(); n++; end
    step();
    bus.in_valid = 1'b0;
    check("push_accept_timeout", 32'(n < 200), 1);
  endtask

  initial begin
    int p0, q0, d0, s0, n, highs;
    logic stable;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b0;

    // Reset values
    do_reset();
    check("rst_count", count, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_heap_push", bus.heap_push, 0);
    check("rst_heap_pop", bus.heap_pop, 0);
    check("rst_heap_data_in", bus.heap_data_in, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Back-to-back pushes are spaced S+2 cycles
    s0 = push_t.size();
    push_key(8'd5);
    push_key(8'd200);
    push_key(8'd17);
    repeat (S + 2) step();
    check("push_strobes", push_t.size() - s0, 3);
    if (push_t.size() - s0 == 3) begin
      check("push_spacing_1", push_t[s0+1] - push_t[s0], S + 2);
      check("push_spacing_2", push_t[s0+2] - push_t[s0+1], S + 2);
    end
    check("count_after_3", count, 3);

    // Drain returns keys in descending order
    do_reset();
    push_key(8'd5);
    push_key(8'd200);
    push_key(8'd17);
    push_key(8'd42);
    exp_q = '{8'd200, 8'd42, 8'd17, 8'd5};
    d0 = n_dd; p0 = n_pop; q0 = pop_t.size();
    bus.out_ready = 1'b1;
    drain = 1'b1;
    n = 0;
    while (n_dd == d0 && n < 400) begin step(); n++; end
    check("drain_done_timeout", 32'(n < 400), 1);
    repeat (20) step();
    check("drain_done_pulses", n_dd - d0, 1);
    check("drain_pops", n_pop - p0, 4);
    check("drain_count", count, 0);
    check("drain_sb_empty", exp_q.size(), 0);
    if (pop_t.size() - q0 >= 2) check("pop_spacing", pop_t[q0+1] - pop_t[q0], S + 3);
    drain = 1'b0;
    bus.out_ready = 1'b0;

    // Full heap refuses further input
    do_reset();
    p0 = n_push;
    for (int k = 0; k < 16; k++) push_key(8'(k));
    repeat (S + 2) step();
    check("full_count", count, 16);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.in_ready) highs++;
      step();
    end
    bus.in_valid = 1'b0;
    check("full_in_ready_highs", highs, 0);
    check("full_push_count", n_push - p0, 16);

    // Output held while consumer stalls
    exp_q.push_back(8'd15);
    p0 = n_pop;
    drain = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 100) begin step(); n++; end
    check("hold_valid_timeout", 32'(n < 100), 1);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!bus.out_valid || bus.out_data !== 8'd15) stable = 1'b0;
      step();
    end
    check("hold_stable", stable, 1);
    check("hold_single_pop", n_pop - p0, 1);
    drain = 1'b0;
    bus.out_ready = 1'b1;
    repeat (15) step();
    check("hold_stop_pops", n_pop - p0, 1);
    check("hold_count", count, 15);
    check("hold_sb_empty", exp_q.size(), 0);

    // Drain raised during a push settle
    do_reset();
    p0 = n_push; d0 = n_dd;
    push_key(8'd9);
    exp_q.push_back(8'd9);
    drain = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd77;
    n = 0;
    while (n_dd == d0 && n < 200) begin step(); n++; end
    check("mid_drain_timeout", 32'(n < 200), 1);
    check("mid_push_count", n_push - p0, 1);
    check("mid_count", count, 0);
    if (push_t.size() > 0 && pop_t.size() > 0)
      check("mid_pop_after_push", pop_t[pop_t.size()-1] - push_t[push_t.size()-1], S + 2);
    drain = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    step();

    // Asynchronous reset during a pop settle
    push_key(8'd30);
    push_key(8'd10);
    push_key(8'd20);
    repeat (S + 2) step();
    p0 = n_pop;
    drain = 1'b1;
    n = 0;
    while (n_pop == p0 && n < 100) begin step(); n++; end
    check("arst_pop_timeout", 32'(n < 100), 1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_data", bus.out_data, 0);
    check("arst_heap_data_in", bus.heap_data_in, 0);
    check("arst_heap_pop", bus.heap_pop, 0);
    drain = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    check("arst_count_release", count, 0);
    check("arst_in_ready", bus.in_ready, 1);

`ifdef HEAP_SEQ_CHECK_EN
    force_not_empty = 1'b1;
    step();
    step();
    check("err_set", err, 1);
    force_not_empty = 1'b0;
    repeat (3) step();
    check("err_sticky", err, 1);
`else
    check("err_tied", err, 0);
`endif

    check("strobe_rules_violations", n_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
